elevator_ctrl_n: RTL

Parametrised N-floor elevator controller. It generalises the fixed 4-floor, direct-select elevator to latched per-floor call requests with SCAN (collective) scheduling, a multi-cycle travel timer per floor, and a door dwell timer with open/close overrides. It sits between the board switch/button inputs and the floor display and door LED.

---
 rtl/elevator_ctrl_n.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller with latched calls, SCAN scheduling, travel and door dwell timers.
// Optional SEG7_OUT_EN adds a registered active-low 7-segment floor display on seg_out.
module elevator_ctrl_n #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8,
  parameter int CNT_W         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  sw_open,
  input  logic                  sw_close,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  door_led,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [CNT_W-1:0]      door_count
`ifdef SEG7_OUT_EN
  ,
  output logic [6:0]            seg_out
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MOVING = 2'd1;
  localparam logic [1:0] ST_DOOR   = 2'd2;

  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  logic [1:0]            state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]      door_count_q, door_count_d;
  logic [CNT_W-1:0]      travel_q, travel_d;

  logic [FLOOR_W-1:0]    step_floor;
  logic                  above_cur, below_cur, above_nxt, below_nxt;
  logic [NUM_FLOORS-1:0] req_mask, clr_mask;

  // Candidate next floor is clamped so the car can never leave the shaft.
  always_comb begin
    step_floor = floor_q;
    if (dir_up_q && floor_q != TOP_FLOOR) begin
      step_floor = floor_q + 1'b1;
    end else if (!dir_up_q && floor_q != '0) begin
      step_floor = floor_q - 1'b1;
    end
  end

  always_comb begin
    above_cur = 1'b0;
    below_cur = 1'b0;
    above_nxt = 1'b0;
    below_nxt = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > floor_q)    above_cur = above_cur | pending_q[i];
      if (FLOOR_W'(i) < floor_q)    below_cur = below_cur | pending_q[i];
      if (FLOOR_W'(i) > step_floor) above_nxt = above_nxt | pending_q[i];
      if (FLOOR_W'(i) < step_floor) below_nxt = below_nxt | pending_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_up_d     = dir_up_q;
    door_count_d = door_count_q;
    travel_d     = travel_q;
    req_mask     = call_req;
    clr_mask     = '0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q[floor_q] || sw_open) begin
          state_d           = ST_DOOR;
          clr_mask[floor_q] = 1'b1;
          door_count_d      = DOOR_LOAD;
        end else if (|pending_q) begin
          // SCAN: keep heading the same way while work remains ahead, else turn around.
          dir_up_d = dir_up_q ? above_cur : ~below_cur;
          state_d  = ST_MOVING;
          travel_d = TRAVEL_LOAD;
        end
      end
      ST_MOVING: begin
        if (travel_q != '0) begin
          travel_d = travel_q - 1'b1;
        end else begin
          floor_d = step_floor;
          if (pending_q[step_floor]) begin
            state_d              = ST_DOOR;
            clr_mask[step_floor] = 1'b1;
            door_count_d         = DOOR_LOAD;
          end else if (dir_up_q ? above_nxt : below_nxt) begin
            travel_d = TRAVEL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DOOR: begin
        // A call for the floor we are already open at just extends the dwell.
        req_mask[floor_q] = 1'b0;
        if (sw_open || call_req[floor_q]) begin
          door_count_d = DOOR_LOAD;
        end else if (door_count_q == '0) begin
          state_d = ST_IDLE;
        end else if (sw_close) begin
          door_count_d = '0;
        end else begin
          door_count_d = door_count_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pending_d = (pending_q | req_mask) & ~clr_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      floor_q      <= '0;
      dir_up_q     <= 1'b1;
      pending_q    <= '0;
      door_count_q <= '0;
      travel_q     <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_up_q     <= dir_up_d;
      pending_q    <= pending_d;
      door_count_q <= door_count_d;
      travel_q     <= travel_d;
    end
  end

  assign current_floor = floor_q;
  assign dir_up        = dir_up_q;
  assign moving        = (state_q == ST_MOVING);
  assign door_open     = (state_q == ST_DOOR);
  assign door_led      = ~door_open;
  assign pending       = pending_q;
  assign door_count    = door_count_q;

`ifdef SEG7_OUT_EN
  logic [6:0] seg_q, seg_d;
  logic [3:0] hex_digit;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  always_comb begin
    hex_digit = 4'(floor_q);
    seg_d     = 7'b1000000;
    case (hex_digit)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      4'hF: seg_d = 7'b0001110;
      default: seg_d = 7'b1000000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= 7'b1000000;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg_out = seg_q;
`endif

endmodule
